cdc_handshake_rx: RTL and testbench
===================================

CDC_HANDSHAKE_RX -- requirements
Module: cdc_handshake_rx

Interface
REQ-001 Parameter P_DATA_MSB, default 31, MSB index of the data bus; data width is P_DATA_MSB+1.
REQ-002 Parameter P_CNT_MSB, default 7, MSB index of the transfer counter; counter width is P_CNT_MSB+1.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 i_clk  input  1  destination-domain clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_req_sync  input  1  4-phase request, already synchronized into i_clk by an upstream synchronizer.
REQ-007 i_data  input  P_DATA_MSB+1  source-held data bus; stable whenever the source request is high.
REQ-008 o_ack  output  1  4-phase acknowledge to the source domain; driven directly from a flop.
REQ-009 o_valid  output  1  captured word available to the local consumer.
REQ-010 o_data  output  P_DATA_MSB+1  captured word, registered.
REQ-011 i_ready  input  1  local consumer accepts o_data when high with o_valid high.
REQ-012 o_xfer_cnt  output  P_CNT_MSB+1  count of completed local handshakes.
REQ-013 o_err  output  1  sticky protocol-error flag.

Function
REQ-014 The FSM SHALL have three states: IDLE, VALID and ACK, and SHALL be encoded so that o_ack is 1 exactly in ACK and o_valid is 1 exactly in VALID.
REQ-015 In IDLE with i_req_sync=1, the block SHALL load o_data from i_data and enter VALID on the same edge, so o_valid=1 the following cycle (1-cycle latency).
REQ-016 In IDLE with i_req_sync=0, the block SHALL hold its state, and o_data SHALL retain its last value.
REQ-017 In VALID, o_valid and o_data SHALL remain stable until a cycle with i_ready=1.
REQ-018 In VALID with i_ready=1, the block SHALL enter ACK (next cycle o_valid=0, o_ack=1) and increment o_xfer_cnt by 1.
REQ-019 o_xfer_cnt SHALL wrap modulo 2^(P_CNT_MSB+1), for example 255 -> 0 at the default width.
REQ-020 In ACK, the block SHALL hold o_ack=1 while i_req_sync=1, with no timeout.
REQ-021 In ACK with i_req_sync=0, the block SHALL return to IDLE (next cycle o_ack=0).
REQ-022 After returning to IDLE, the block SHALL NOT start a new capture before a cycle in which i_req_sync=1 is sampled in IDLE, so the minimum IDLE dwell is one cycle.
REQ-023 In VALID with i_req_sync=0 (request dropped before ack), the block SHALL set o_err=1.
REQ-024 After the early request drop, the transfer SHALL complete normally: o_valid is held until consumed, and ACK is then left on the first cycle since i_req_sync is already 0.
REQ-025 If i_req_sync=0 and i_ready=1 occur in the same VALID cycle, the block SHALL set o_err and enter ACK in that same edge.
REQ-026 o_err SHALL stay set until reset; no other condition clears it.
REQ-027 i_ready SHALL be ignored outside VALID.
REQ-028 Changes on i_data SHALL be ignored outside the IDLE capture edge.
REQ-029 An elaboration-time check SHALL print a [COMPILE-ERROR] block if P_DATA_MSB<0 or P_CNT_MSB<0.

Reset
REQ-030 On i_rst=1 at a rising edge, the block SHALL go to IDLE with o_ack=0, o_valid=0, o_data=0, o_xfer_cnt=0 and o_err=0.
REQ-031 Reset SHALL take priority over every other event, including mid-transfer in VALID or ACK.
REQ-032 After a mid-transfer reset, o_ack SHALL be 0 regardless of i_req_sync.
REQ-033 If i_req_sync is still 1 on the first edge after reset is released, a new capture SHALL start; the source is responsible for re-synchronization.

Verification
REQ-034 Basic transfer: i_data=0xDEADBEEF, i_req_sync 0->1 -> o_valid=1 and o_data=0xDEADBEEF 1 cycle later; i_ready=1 -> o_ack=1 next cycle and o_xfer_cnt=1; i_req_sync->0 -> o_ack=0 next cycle.
REQ-035 Backpressure: i_ready=0 for 10 cycles in VALID while i_data changes to 0x12345678 -> o_valid=1 and o_data=0xDEADBEEF held throughout; o_ack=0 throughout.
REQ-036 Protocol error: i_req_sync drops during VALID -> o_err=1 and remains 1; i_ready=1 -> o_ack high for exactly 1 cycle, then IDLE.
REQ-037 Counter wrap: 256 back-to-back transfers at default width -> o_xfer_cnt returns to 0, with no lost or duplicated o_valid.
REQ-038 Reset in ACK with i_req_sync=1: next cycle all outputs are 0; after release, a new capture occurs on the first edge.
REQ-039 Random source/consumer delays over 10k transfers: every source word SHALL be seen exactly once on o_data, in order, with o_err=0.

Source files
------------

// File: rtl/cdc_handshake_rx.sv
// Destination-side receiver of a 4-phase request/acknowledge CDC handshake.
// The source holds i_data stable while its request is high; the request
// arrives here already synchronized as i_req_sync.  A captured word is
// offered to the local consumer over a valid/ready pair.
//
// Local handshake: o_data is transferred on a rising edge where
// o_valid=1 and i_ready=1; while o_valid=1 and i_ready=0, o_valid and
// o_data hold.  i_ready has no effect when o_valid=0.
module cdc_handshake_rx #(
  parameter int P_DATA_MSB = 31,
  parameter int P_CNT_MSB  = 7
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_sync,
  input  logic [P_DATA_MSB:0] i_data,
  output logic                o_ack,
  output logic                o_valid,
  output logic [P_DATA_MSB:0] o_data,
  input  logic                i_ready,
  output logic [P_CNT_MSB:0]  o_xfer_cnt,
  output logic                o_err
);

  // One-hot-ish encoding: bit 0 is o_valid and bit 1 is o_ack, so both
  // outputs come straight from the state flops.  The state is therefore
  // fully visible on o_valid/o_ack.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_VALID = 2'b01;
  localparam logic [1:0] ST_ACK   = 2'b10;

  localparam logic [P_CNT_MSB:0] CNT_ONE = 1;

  // Reject degenerate widths at elaboration.
  generate
    if (P_DATA_MSB < 0 || P_CNT_MSB < 0) begin : g_param_check
      $error("[COMPILE-ERROR] cdc_handshake_rx: P_DATA_MSB (%0d) and P_CNT_MSB (%0d) must be >= 0",
             P_DATA_MSB, P_CNT_MSB);
    end
  endgenerate

  logic [1:0]          state;
  logic [P_DATA_MSB:0] data_q;
  logic [P_CNT_MSB:0]  cnt_q;
  logic                err_q;

  // Handshake FSM, capture register, transfer counter and sticky error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      data_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Data is only sampled here; the source guarantees it is stable.
          if (i_req_sync) begin
            data_q <= i_data;
            state  <= ST_VALID;
          end
        end
        ST_VALID: begin
          // Request dropped before we acknowledged: flag it, but still
          // finish the local transfer so the word is not lost.
          if (!i_req_sync) begin
            err_q <= 1'b1;
          end
          if (i_ready) begin
            cnt_q <= cnt_q + CNT_ONE;
            state <= ST_ACK;
          end
        end
        ST_ACK: begin
          // Hold the acknowledge for as long as the source requests.
          if (!i_req_sync) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_valid    = state[0];
  assign o_ack      = state[1];
  assign o_data     = data_q;
  assign o_xfer_cnt = cnt_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Directed and randomized-delay bench for cdc_handshake_rx.
module tb_cdc_handshake_rx;

  localparam int DW = 32;
  localparam int CW = 8;

  // Clock / reset
  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [DW-1:0] data_in;
  logic          ready;
  logic          ack;
  logic          valid;
  logic [DW-1:0] data_out;
  logic [CW-1:0] cnt;
  logic          err;

  always #5 clk = ~clk;

  cdc_handshake_rx #(.P_DATA_MSB(DW-1), .P_CNT_MSB(CW-1)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_sync (req),
    .i_data     (data_in),
    .o_ack      (ack),
    .o_valid    (valid),
    .o_data     (data_out),
    .i_ready    (ready),
    .o_xfer_cnt (cnt),
    .o_err      (err)
  );

  // Scoreboard
  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] exp_cnt;
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: one complete transfer with the given idle/backpressure/ack-hold delays.
  task automatic xfer(input logic [DW-1:0] w, input int d_idle, input int d_ready, input int d_ack);
    for (int i = 0; i < d_idle; i++) tick();
    req     = 1'b1;
    data_in = w;
    exp_q.push_back(w);
    tick();
    // Source data may wander while we are not capturing.
    for (int i = 0; i < d_ready; i++) begin
      data_in = $urandom;
      tick();
    end
    chk("xfer_valid", valid, 1'b1);
    ready = 1'b1;
    chk("xfer_data", data_out, exp_q.pop_front());
    tick();
    ready   = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    for (int i = 0; i < d_ack; i++) tick();
    req = 1'b0;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"},   ack,      1'b0);
    chk({tag, "_valid"}, valid,    1'b0);
    chk({tag, "_data"},  data_out, 32'h0);
    chk({tag, "_cnt"},   cnt,      8'h0);
    chk({tag, "_err"},   err,      1'b0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; data_in = '0; ready = 1'b0; exp_cnt = '0;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Basic transfer
    data_in = 32'hDEADBEEF; req = 1'b1;
    tick();
    chk("basic_valid", valid, 1'b1);
    chk("basic_data", data_out, 32'hDEADBEEF);
    chk("basic_ack0", ack, 1'b0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("basic_valid_off", valid, 1'b0);
    chk("basic_ack", ack, 1'b1);
    chk("basic_cnt", cnt, 8'd1);
    tick();
    chk("basic_ack_hold", ack, 1'b1);
    req = 1'b0;
    tick();
    chk("basic_ack_drop", ack, 1'b0);
    chk("basic_idle_valid", valid, 1'b0);

    // Ready in IDLE is ignored; data retained
    ready = 1'b1; data_in = 32'h0BADF00D;
    tick(); tick();
    chk("idle_ready_cnt", cnt, 8'd1);
    chk("idle_ready_valid", valid, 1'b0);
    chk("idle_data_kept", data_out, 32'hDEADBEEF);
    ready = 1'b0;

    // Backpressure
    data_in = 32'hDEADBEEF; req = 1'b1;
    tick();
    data_in = 32'h12345678;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", valid, 1'b1);
      chk("bp_data", data_out, 32'hDEADBEEF);
      chk("bp_ack", ack, 1'b0);
      tick();
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("bp_ack_rise", ack, 1'b1);
    chk("bp_cnt", cnt, 8'd2);
    req = 1'b0;
    tick();
    chk("bp_ack_drop", ack, 1'b0);

    // Protocol error: request drops during VALID
    data_in = 32'hA5A5A5A5; req = 1'b1;
    tick();
    chk("err_valid", valid, 1'b1);
    chk("err_clear", err, 1'b0);
    req = 1'b0;
    tick();
    chk("err_set", err, 1'b1);
    chk("err_valid_held", valid, 1'b1);
    chk("err_data_held", data_out, 32'hA5A5A5A5);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("err_ack", ack, 1'b1);
    chk("err_cnt", cnt, 8'd3);
    tick();
    chk("err_ack_1cyc", ack, 1'b0);
    chk("err_idle_valid", valid, 1'b0);
    chk("err_sticky", err, 1'b1);

    // Counter wrap: 253 more back-to-back transfers brings the total to 256
    exp_cnt = 8'd3;
    for (int i = 0; i < 253; i++) xfer(32'h1000_0000 + i, 0, 0, 0);
    chk("wrap_cnt", cnt, 8'd0);
    chk("wrap_model_cnt", cnt, exp_cnt);
    chk("wrap_q_empty", exp_q.size(), 0);
    chk("wrap_err_sticky", err, 1'b1);

    // Reset in ACK with request still high
    data_in = 32'hCAFEF00D; req = 1'b1;
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("rack_ack", ack, 1'b1);
    rst = 1'b1;
    tick();
    check_all_zero("rack");
    rst = 1'b0; data_in = 32'h5EED5EED;
    tick();
    chk("rack_recap_valid", valid, 1'b1);
    chk("rack_recap_data", data_out, 32'h5EED5EED);
    // Request drop and ready in the same VALID cycle
    req = 1'b0; ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("same_err", err, 1'b1);
    chk("same_ack", ack, 1'b1);
    chk("same_cnt", cnt, 8'd1);
    tick();
    chk("same_idle", ack, 1'b0);

    // Random delays over 10k transfers
    rst = 1'b1;
    tick();
    rst = 1'b0; exp_cnt = '0;
    tick();
    for (int i = 0; i < 10000; i++)
      xfer($urandom, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    chk("rand_cnt", cnt, exp_cnt);
    chk("rand_err", err, 1'b0);
    chk("rand_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
